// File: rtl/fp_mul_pkg.sv
// Shared types and width-generic encoding helpers for the sequential FP multiplier.
// Helpers return a 64-bit vector; callers keep the low EXP_W+MAN_W+1 bits.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MULT   = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } rmode_t;

  localparam int FP_MAX_W = 64;

  function automatic logic [FP_MAX_W-1:0] exp_ones(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [FP_MAX_W-1:0] qnan(input int exp_w, input int man_w);
    return exp_ones(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [FP_MAX_W-1:0] inf(input logic sign, input int exp_w, input int man_w);
    return ({63'd0, sign} << (exp_w + man_w)) | exp_ones(exp_w, man_w);
  endfunction

  function automatic logic [FP_MAX_W-1:0] max_finite(input logic sign, input int exp_w,
                                                     input int man_w);
    return ({63'd0, sign} << (exp_w + man_w))
         | (exp_ones(exp_w, man_w) - (64'd1 << man_w))
         | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_mul_mantissa_seq.sv
// Radix-2 shift-add significand multiplier: bit 0 of b is consumed on the load
// edge, the remaining W-1 bits one per cycle; done_o pulses with p_o final.
module fp_mul_mantissa_seq
  import fp_mul_pkg::*;
#(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] p_o
);

  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic           run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        acc    <= b_i[0] ? {{W{1'b0}}, a_i} : '0;
        mcand  <= {{(W-1){1'b0}}, a_i, 1'b0};
        mplier <= b_i >> 1;
        cnt    <= CNT_W'(1);
        run    <= 1'b1;
      end else if (run) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (cnt == LAST) begin
          run    <= 1'b0;
          done_o <= 1'b1;
        end
      end
    end
  end

  assign p_o = acc;

endmodule

// File: rtl/fp_multiplier_seq.sv
// Sequential IEEE-754-style multiplier with generic widths, four rounding modes
// and flush-to-zero of denormals on both operands and result.
module fp_multiplier_seq
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  input  logic [1:0]           rm_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [EXP_W+MAN_W:0] product_o,
  output logic                 nan_o,
  output logic                 inifinit_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int FP_W  = EXP_W + MAN_W + 1;
  localparam int SIG_W = MAN_W + 1;
  localparam int E_W   = EXP_W + 2;
  localparam logic signed [E_W-1:0] BIAS    = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_UNPACK = 3'(UNPACK);
  localparam logic [2:0] ST_MULT   = 3'(MULT);
  localparam logic [2:0] ST_NORM   = 3'(NORM);
  localparam logic [2:0] ST_ROUND  = 3'(ROUND);
  localparam logic [2:0] ST_DONE   = 3'(DONE);

  logic [2:0] state, state_nxt;
  logic [FP_W-1:0] a_q, b_q;
  rmode_t rm_q;
  logic sign_q;
  logic signed [E_W-1:0] exp_q;
  logic [MAN_W-1:0] man_q;
  logic g_q, r_q, s_q;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic is_nan, is_inf, special, sign_ab, accept, mul_start, mul_done;
  logic signed [E_W-1:0] exp_sum;
  logic [2*SIG_W-1:0] p;
  logic [2*SIG_W-2:0] p_norm;
  logic [FP_W-1:0] spec_res, rnd_res;
  logic [3:0] spec_flags, rnd_flags;
  logic lsb_inc, carry, to_inf;
  logic [MAN_W-1:0] man_rnd;
  logic signed [E_W-1:0] exp_rnd;

  assign ea = a_q[FP_W-2 -: EXP_W];
  assign eb = b_q[FP_W-2 -: EXP_W];
  assign ma = a_q[MAN_W-1:0];
  assign mb = b_q[MAN_W-1:0];
  assign sign_ab = a_q[FP_W-1] ^ b_q[FP_W-1];

  // exp == 0 means zero: denormal operands are flushed here
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) & ~(|ma);
  assign b_inf  = (&eb) & ~(|mb);
  assign a_nan  = (&ea) & (|ma);
  assign b_nan  = (&eb) & (|mb);
  assign is_nan = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign is_inf = a_inf | b_inf;
  assign special = is_nan | is_inf | a_zero | b_zero;
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  assign accept    = ((state == ST_IDLE) || (state == ST_DONE)) && start_i;
  assign mul_start = (state == ST_UNPACK) && !special;
  assign busy_o    = (state != ST_IDLE) && (state != ST_DONE);
  assign done_o    = (state == ST_DONE);

  fp_mul_mantissa_seq #(.W(SIG_W)) u_mant (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     ({1'b1, ma}),
    .b_i     ({1'b1, mb}),
    .done_o  (mul_done),
    .p_o     (p)
  );

  // Left-align so the hidden bit always sits just above the kept mantissa
  assign p_norm = p[2*SIG_W-1] ? p[2*SIG_W-2:0] : {p[2*SIG_W-3:0], 1'b0};

  always_comb begin
    spec_res   = {sign_ab, {(FP_W-1){1'b0}}};
    spec_flags = 4'b0000;
    if (is_nan) begin
      spec_res   = FP_W'(qnan(EXP_W, MAN_W));
      spec_flags = 4'b1000;
    end else if (is_inf) begin
      spec_res   = FP_W'(inf(sign_ab, EXP_W, MAN_W));
      spec_flags = 4'b0100;
    end
  end

  always_comb begin
    case (rm_q)
      RNE:     lsb_inc = g_q & (r_q | s_q | man_q[0]);
      RUP:     lsb_inc = ~sign_q & (g_q | r_q | s_q);
      RDN:     lsb_inc = sign_q & (g_q | r_q | s_q);
      default: lsb_inc = 1'b0;
    endcase
    {carry, man_rnd} = {1'b0, man_q} + {{MAN_W{1'b0}}, lsb_inc};
    exp_rnd = exp_q + {{(E_W-1){1'b0}}, carry};
    to_inf  = (rm_q == RNE) || ((rm_q == RUP) && !sign_q) || ((rm_q == RDN) && sign_q);
    rnd_res   = {sign_q, exp_rnd[EXP_W-1:0], man_rnd};
    rnd_flags = 4'b0000;
    if (exp_rnd >= EXP_MAX) begin
      rnd_res   = to_inf ? FP_W'(inf(sign_q, EXP_W, MAN_W))
                         : FP_W'(max_finite(sign_q, EXP_W, MAN_W));
      rnd_flags = {1'b0, to_inf, 1'b1, 1'b0};
    end else if (exp_rnd[E_W-1] || (exp_rnd == '0)) begin
      rnd_res   = {sign_q, {(FP_W-1){1'b0}}};
      rnd_flags = 4'b0001;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_i) state_nxt = ST_UNPACK;
      ST_UNPACK: state_nxt = special ? ST_DONE : ST_MULT;
      ST_MULT:   if (mul_done) state_nxt = ST_NORM;
      ST_NORM:   state_nxt = ST_ROUND;
      ST_ROUND:  state_nxt = ST_DONE;
      ST_DONE:   state_nxt = start_i ? ST_UNPACK : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      rm_q        <= RNE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      man_q       <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      product_o   <= '0;
      nan_o       <= 1'b0;
      inifinit_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q  <= a_i;
        b_q  <= b_i;
        rm_q <= rmode_t'(rm_i);
      end
      case (state)
        ST_UNPACK: begin
          sign_q <= sign_ab;
          exp_q  <= exp_sum;
          if (special) begin
            product_o <= spec_res;
            {nan_o, inifinit_o, overflow_o, underflow_o} <= spec_flags;
          end
        end
        ST_NORM: begin
          man_q <= p_norm[2*SIG_W-2 -: MAN_W];
          g_q   <= p_norm[MAN_W];
          r_q   <= p_norm[MAN_W-1];
          s_q   <= |p_norm[MAN_W-2:0];
          exp_q <= exp_q + {{(E_W-1){1'b0}}, p[2*SIG_W-1]};
        end
        ST_ROUND: begin
          product_o <= rnd_res;
          {nan_o, inifinit_o, overflow_o, underflow_o} <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Self-checking bench for fp_multiplier_seq: single and half precision instances,
// expected results queued on drive and compared when done_o pulses.
module tb_fp_multiplier_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        start32 = 1'b0, start16 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [1:0]  rm32 = 2'd0, rm16 = 2'd0;
  logic        busy32, done32, nan32, inf32, ovf32, unf32;
  logic        busy16, done16, nan16, inf16, ovf16, unf16;
  logic [31:0] prod32;
  logic [15:0] prod16;

  typedef struct {
    string       tag;
    logic [31:0] p;
    logic [3:0]  f;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  int checks = 0;
  int errors = 0;
  int dones32 = 0;

  fp_multiplier_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start32), .a_i(a32), .b_i(b32), .rm_i(rm32),
    .busy_o(busy32), .done_o(done32), .product_o(prod32), .nan_o(nan32),
    .inifinit_o(inf32), .overflow_o(ovf32), .underflow_o(unf32)
  );

  fp_multiplier_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .start_i(start16), .a_i(a16), .b_i(b16), .rm_i(rm16),
    .busy_o(busy16), .done_o(done16), .product_o(prod16), .nan_o(nan16),
    .inifinit_o(inf16), .overflow_o(ovf16), .underflow_o(unf16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Correctly rounded (RNE) single-precision product for normal, in-range operands
  function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p, rem, half;
    logic [24:0] q;
    int e, sh;
    p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = p[47] ? 24 : 23;
    if (p[47]) e++;
    q    = 25'(p >> sh);
    rem  = p & ((48'd1 << sh) - 48'd1);
    half = 48'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 25'd1;
    if (q[24]) begin
      q = q >> 1;
      e++;
    end
    return {a[31] ^ b[31], e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] randNormal();
    logic [7:0] e;
    e = 8'($urandom_range(150, 100));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  always @(negedge clk) begin : mon32
    exp_t e;
    if (done32) begin
      dones32++;
      if (q32.size() == 0) checkOutput("dut32 unexpected done", 64'(done32), 64'd0);
      else begin
        e = q32.pop_front();
        checkOutput({e.tag, " product"}, 64'(prod32), 64'(e.p));
        checkOutput({e.tag, " flags"}, 64'({nan32, inf32, ovf32, unf32}), 64'(e.f));
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (done16) begin
      if (q16.size() == 0) checkOutput("dut16 unexpected done", 64'(done16), 64'd0);
      else begin
        e = q16.pop_front();
        checkOutput({e.tag, " product"}, 64'({16'd0, prod16}), 64'(e.p));
        checkOutput({e.tag, " flags"}, 64'({nan16, inf16, ovf16, unf16}), 64'(e.f));
      end
    end
  end

  task automatic applyStimulus(input string tag, input bit half, input logic [31:0] a,
                               input logic [31:0] b, input logic [1:0] rm,
                               input logic [31:0] ep, input logic [3:0] ef, input int lat);
    exp_t e;
    int n;
    e.tag = tag;
    e.p   = ep;
    e.f   = ef;
    @(negedge clk);
    if (half) begin
      a16 = a[15:0]; b16 = b[15:0]; rm16 = rm; start16 = 1'b1;
      q16.push_back(e);
    end else begin
      a32 = a; b32 = b; rm32 = rm; start32 = 1'b1;
      q32.push_back(e);
    end
    @(posedge clk);
    #1;
    start16 = 1'b0;
    start32 = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(half ? done16 : done32) && n < 200);
    checkOutput({tag, " latency"}, 64'(n), 64'(lat));
  endtask

  initial begin
    int base;
    logic [31:0] va, vb;
    exp_t e;

    #2 rst_n = 1'b0;
    #20;
    checkOutput("reset product", 64'(prod32), 64'd0);
    checkOutput("reset flags", 64'({nan32, inf32, ovf32, unf32}), 64'd0);
    checkOutput("reset busy/done", 64'({busy32, done32, busy16, done16}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("3x2 rne", 0, 32'h40400000, 32'h40000000, 2'd0, 32'h40C00000, 4'b0000, 27);
    applyStimulus("inf x 0", 0, 32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 4'b1000, 1);
    applyStimulus("-inf x 2", 0, 32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 4'b0100, 1);
    applyStimulus("nan x 1", 0, 32'h7FC00001, 32'h3F800000, 2'd1, 32'h7FC00000, 4'b1000, 1);
    applyStimulus("-0 x 2", 0, 32'h80000000, 32'h40000000, 2'd0, 32'h80000000, 4'b0000, 1);
    applyStimulus("ovf rne", 0, 32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000, 4'b0110, 27);
    applyStimulus("ovf rtz", 0, 32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'b0010, 27);
    applyStimulus("-ovf rdn", 0, 32'hFF7FFFFF, 32'h40000000, 2'd3, 32'hFF800000, 4'b0110, 27);
    applyStimulus("-ovf rup", 0, 32'hFF7FFFFF, 32'h40000000, 2'd2, 32'hFF7FFFFF, 4'b0010, 27);
    applyStimulus("unf min^2", 0, 32'h00800000, 32'h00800000, 2'd0, 32'h00000000, 4'b0001, 27);
    applyStimulus("unf e=0", 0, 32'h00800000, 32'h3F000000, 2'd0, 32'h00000000, 4'b0001, 27);
    applyStimulus("min x 1", 0, 32'h00800000, 32'h3F800000, 2'd0, 32'h00800000, 4'b0000, 27);
    applyStimulus("1+ulp rne", 0, 32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'b0000, 27);
    applyStimulus("1+ulp rup", 0, 32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'b0000, 27);
    applyStimulus("1+ulp rtz", 0, 32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'b0000, 27);

    applyStimulus("h 1x2", 1, 32'h3C00, 32'h4000, 2'd0, 32'h4000, 4'b0000, 14);
    applyStimulus("h ovf rdn", 1, 32'h7BFF, 32'h4000, 2'd3, 32'h7BFF, 4'b0010, 14);
    applyStimulus("h -2x1.5", 1, 32'hC000, 32'h3E00, 2'd0, 32'hC200, 4'b0000, 14);

    // Back-to-back random operations with start held high
    repeat (3) @(negedge clk);
    base = dones32;
    va = randNormal();
    vb = randNormal();
    a32 = va; b32 = vb; rm32 = 2'd0; start32 = 1'b1;
    e.tag = "random"; e.p = refMul(va, vb); e.f = 4'b0000;
    q32.push_back(e);
    for (int i = 0; i < 100; i++) begin
      int n;
      n = 0;
      @(posedge clk);
      do begin
        @(negedge clk);
        n++;
      end while (!done32 && n < 200);
      checkOutput("random done seen", 64'(done32), 64'd1);
      if (!done32) break;
      if (i < 99) begin
        va = randNormal();
        vb = randNormal();
        a32 = va; b32 = vb;
        e.p = refMul(va, vb);
        q32.push_back(e);
      end else begin
        start32 = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    checkOutput("random done count", 64'(dones32 - base), 64'd100);

    // Async reset in the middle of MULT discards the operation
    base = dones32;
    @(negedge clk);
    a32 = 32'h40400000; b32 = 32'h40000000; rm32 = 2'd0; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset product", 64'(prod32), 64'd0);
    checkOutput("midreset flags", 64'({nan32, inf32, ovf32, unf32}), 64'd0);
    checkOutput("midreset busy", 64'({busy32, done32}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("midreset no done", 64'(dones32 - base), 64'd0);
    checkOutput("queue32 drained", 64'(q32.size()), 64'd0);
    checkOutput("queue16 drained", 64'(q16.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
